mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between instruction fetch (IF) and the MEM-stage load/store path of the 5-stage pipeline CPU.
//  Arbitrates the two requesters and runs a ready-handshake memory transaction for the winner.
//  Returns read data with a one-cycle ack pulse and drives a pipeline stall while any request is still outstanding.
//  Sits between PC/IF_ID and EX_MEM on the CPU side and the external memory on the other side.
// PARAMETERS
//  ADDR_W      32  address width, all address ports
//  DATA_W      32  data width, all data ports
//  STARVE_MAX  4   consecutive DM grants taken while IF waits before IF is forced to win once
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       reset, asynchronous, active-low
//  if_req_i     in   1       fetch request; held high until if_ack_o
//  if_addr_i    in   ADDR_W  fetch address
//  if_data_o    out  DATA_W  fetched instruction; valid when if_ack_o=1
//  if_ack_o     out  1       one-cycle fetch completion pulse
//  dm_req_i     in   1       data request; held high until dm_ack_o
//  dm_we_i      in   1       1=store, 0=load
//  dm_addr_i    in   ADDR_W  data address
//  dm_wdata_i   in   DATA_W  store data
//  dm_rdata_o   out  DATA_W  load data; valid when dm_ack_o=1 for a load
//  dm_ack_o     out  1       one-cycle data completion pulse
//  mem_en_o     out  1       memory transaction active
//  mem_we_o     out  1       memory write enable
//  mem_addr_o   out  ADDR_W  memory address
//  mem_wdata_o  out  DATA_W  memory write data
//  mem_rdata_i  in   DATA_W  memory read data; valid with mem_ready_i
//  mem_ready_i  in   1       memory completes the current transaction
//  stall_o      out  1       freeze PC/pipeline registers
// BEHAVIOUR
//  - Reset (rst_i=0, any time): state=IDLE, starve_cnt=0, and all outputs 0, including data registers.
//    An in-flight transaction is abandoned and no ack is issued.
//  - FSM IDLE -> GRANT_DM | GRANT_IF -> RESP -> IDLE.
//  - IDLE arbitration when at least one request is high:
//    - dm_req_i wins, unless if_req_i=1 and starve_cnt==STARVE_MAX; then IF wins.
//    - DM win with if_req_i=1: starve_cnt++ (saturating). Any IF win: starve_cnt=0.
//  - GRANT_x: mem_en_o=1. mem_addr_o, mem_we_o and mem_wdata_o are registered at grant and held stable until mem_ready_i.
//    For IF, mem_we_o=0. Wait states are unbounded.
//  - mem_ready_i=1 in GRANT_x: capture mem_rdata_i (loads and fetches only) and go to RESP. mem_en_o drops in RESP.
//  - RESP: the granted requester's ack_o=1 for exactly one cycle; its data_o holds the captured value.
//    dm_rdata_o is unchanged by stores. Data outputs hold their value until the next capture.
//  - Latency: request seen in IDLE at cycle N -> mem_en_o at N+1. mem_ready_i at cycle M -> ack at M+1.
//    Minimum request-to-ack is 2 cycles. Back-to-back transactions cost an extra IDLE cycle.
//  - mem_ready_i is ignored outside GRANT_x.
//  - A request dropped mid-transaction does not cancel it: the transaction completes and the ack is still pulsed.
//  - Requests are re-evaluated only in IDLE. A stale request seen in RESP is never granted.
//  - stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational.
//    It is 0 in the ack cycle so the pipeline advances.
//  - Both acks are never high in the same cycle.
// STRUCTURE
//  - Shared package mem_arb_pkg:
//    - state enum {IDLE, GRANT_IF, GRANT_DM, RESP}
//    - grant-owner encoding {OWN_IF, OWN_DM}
//    - default widths
//  - Sub-module mem_arb_starve_ctr: saturating counter with inc/clr inputs and an at_max output.
//  - All other logic stays in this file.
// TESTING
//  1. Reset mid-transfer: assert rst_i=0 during GRANT_DM -> all outputs 0 immediately.
//     Release -> IDLE, and no dm_ack_o ever follows.
//  2. Fetch: if_req_i=1, addr=0x10; mem_ready_i 3 cycles after mem_en_o rises, rdata=0x00500093.
//     -> mem_addr_o=0x10, mem_we_o=0, stall_o=1 until ack; if_ack_o pulses 1 cycle; if_data_o=0x00500093.
//  3. Simultaneous if_req_i (0x20) and dm load (0x40) -> DM granted first with mem_addr_o=0x40 and dm_ack_o.
//     Then IF granted with mem_addr_o=0x20 and if_ack_o.
//  4. Starvation, STARVE_MAX=2: dm_req_i re-raised right after each ack, if_req_i held -> grant order DM, DM, IF, DM.
//  5. Store: dm_we_i=1, addr=0x80, wdata=0xDEADBEEF, ready after 2 wait cycles.
//     -> mem_we_o=1, addr and wdata stable throughout; dm_ack_o pulses; dm_rdata_o unchanged.
//  6. mem_ready_i=1 while IDLE with no request -> no ack, no state change.
//     if_req_i dropped mid-grant -> if_ack_o still pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the IF/MEM memory port arbiter.
// Rev 1.0
`default_nettype none

package mem_arb_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_DM = 2'd2,
    RESP     = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Counter width able to hold 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of DM grants taken while IF was waiting.
// Rev 1.0
`default_nettype none

module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX = DEF_STARVE_MAX
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int            W     = cnt_width(MAX);
  localparam logic [W-1:0]  MAX_V = W'(MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign at_max = (cnt == MAX_V);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and MEM-stage loads/stores.
// Rev 1.0
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              stall_o
);

  arb_state_t        state, state_nxt;
  owner_t            owner;
  logic              grant_if, grant_dm;
  logic              starve_at_max;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] dm_rdata_q;

  mem_arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc    (grant_dm & if_req_i),
    .clr    (grant_if),
    .at_max (starve_at_max)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DM normally wins; a starved IF gets exactly one forced win.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    unique case (state)
      IDLE: begin
        if (dm_req_i && !(if_req_i && starve_at_max)) begin
          grant_dm  = 1'b1;
          state_nxt = GRANT_DM;
        end else if (if_req_i) begin
          grant_if  = 1'b1;
          state_nxt = GRANT_IF;
        end
      end
      GRANT_IF, GRANT_DM: begin
        if (mem_ready_i) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner      <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (grant_dm) begin
        owner   <= OWN_DM;
        we_q    <= dm_we_i;
        addr_q  <= dm_addr_i;
        wdata_q <= dm_wdata_i;
      end else if (grant_if) begin
        owner   <= OWN_IF;
        we_q    <= 1'b0;
        addr_q  <= if_addr_i;
        wdata_q <= '0;
      end
      if (mem_ready_i && (state == GRANT_IF)) begin
        if_data_q <= mem_rdata_i;
      end
      if (mem_ready_i && (state == GRANT_DM) && !we_q) begin
        dm_rdata_q <= mem_rdata_i;
      end
    end
  end

  assign mem_en_o    = (state == GRANT_IF) || (state == GRANT_DM);
  assign mem_we_o    = we_q & mem_en_o;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_ack_o    = (state == RESP) && (owner == OWN_IF);
  assign dm_ack_o    = (state == RESP) && (owner == OWN_DM);
  assign if_data_o   = if_data_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign stall_o     = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, corner sequences and randomized model check.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  localparam int SMAX = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, dm_req_i, dm_we_i, mem_ready_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic [31:0] if_data_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ack_o, dm_ack_o, mem_en_o, mem_we_o, stall_o;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_data_o   (if_data_o),
    .if_ack_o    (if_ack_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_ack_o    (dm_ack_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i),
    .stall_o     (stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        e_if_ack;
    logic        e_dm_ack;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic [31:0] e_if_data;
    logic [31:0] e_dm_data;
  } vec_t;

  vec_t tbl[$];

  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dwd, input logic rdy, input logic [31:0] rd,
    input logic eia, input logic eda, input logic een, input logic ewe,
    input logic [31:0] ea, input logic [31:0] ewd, input logic est,
    input logic [31:0] eid, input logic [31:0] edd);
    vec_t v;
    v.if_req = ir;  v.if_addr = ia;  v.dm_req = dr;  v.dm_we = dw;
    v.dm_addr = da; v.dm_wdata = dwd; v.ready = rdy; v.rdata = rd;
    v.e_if_ack = eia; v.e_dm_ack = eda; v.e_en = een; v.e_we = ewe;
    v.e_addr = ea; v.e_wdata = ewd; v.e_stall = est;
    v.e_if_data = eid; v.e_dm_data = edd;
    return v;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic idle_inputs();
    if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    dm_addr_i = '0; dm_wdata_i = '0; mem_ready_i = 1'b0; mem_rdata_i = '0;
  endtask

  initial begin
    // random-phase model state
    int          mode;
    bit          t_if, t_we, pick_if, if_busy, dm_busy;
    logic [31:0] t_addr, t_wdata, m_if_data, m_dm_data;
    int          wait_left, starve;
    bit          e_ia, e_da;
    int          order[$];
    int          exp_order[4];

    rst_i = 1'b0;
    idle_inputs();

    // Fetch; simultaneous IF+DM load; store; ready while idle.
    tbl.push_back(mk(1,32'h10,0,0,0,0, 0,0,          0,0,0,0,0,0,1, 0,0));
    tbl.push_back(mk(1,32'h10,0,0,0,0, 0,0,          0,0,1,0,32'h10,0,1, 0,0));
    tbl.push_back(mk(1,32'h10,0,0,0,0, 0,0,          0,0,1,0,32'h10,0,1, 0,0));
    tbl.push_back(mk(1,32'h10,0,0,0,0, 0,0,          0,0,1,0,32'h10,0,1, 0,0));
    tbl.push_back(mk(1,32'h10,0,0,0,0, 1,32'h00500093, 0,0,1,0,32'h10,0,1, 0,0));
    tbl.push_back(mk(0,32'h10,0,0,0,0, 0,0,          1,0,0,0,0,0,0, 32'h00500093,0));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,          0,0,0,0,0,0,0, 32'h00500093,0));
    tbl.push_back(mk(1,32'h20,1,0,32'h40,0, 0,0,     0,0,0,0,0,0,1, 32'h00500093,0));
    tbl.push_back(mk(1,32'h20,1,0,32'h40,0, 1,32'h11112222, 0,0,1,0,32'h40,0,1, 32'h00500093,0));
    tbl.push_back(mk(1,32'h20,0,0,0,0, 0,0,          0,1,0,0,0,0,1, 32'h00500093,32'h11112222));
    tbl.push_back(mk(1,32'h20,0,0,0,0, 0,0,          0,0,0,0,0,0,1, 32'h00500093,32'h11112222));
    tbl.push_back(mk(1,32'h20,0,0,0,0, 1,32'h33334444, 0,0,1,0,32'h20,0,1, 32'h00500093,32'h11112222));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,          1,0,0,0,0,0,0, 32'h33334444,32'h11112222));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,          0,0,0,0,0,0,0, 32'h33334444,32'h11112222));
    tbl.push_back(mk(0,0,1,1,32'h80,32'hDEADBEEF, 0,0, 0,0,0,0,0,0,1, 32'h33334444,32'h11112222));
    tbl.push_back(mk(0,0,1,1,32'h80,32'hDEADBEEF, 0,0, 0,0,1,1,32'h80,32'hDEADBEEF,1, 32'h33334444,32'h11112222));
    tbl.push_back(mk(0,0,1,1,32'h80,32'hDEADBEEF, 0,0, 0,0,1,1,32'h80,32'hDEADBEEF,1, 32'h33334444,32'h11112222));
    tbl.push_back(mk(0,0,1,1,32'h80,32'hDEADBEEF, 1,32'hAAAAAAAA, 0,0,1,1,32'h80,32'hDEADBEEF,1, 32'h33334444,32'h11112222));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,          0,1,0,0,0,0,0, 32'h33334444,32'h11112222));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,          0,0,0,0,0,0,0, 32'h33334444,32'h11112222));
    tbl.push_back(mk(0,0,0,0,0,0,      1,32'hFFFFFFFF, 0,0,0,0,0,0,0, 32'h33334444,32'h11112222));
    tbl.push_back(mk(0,0,0,0,0,0,      0,0,          0,0,0,0,0,0,0, 32'h33334444,32'h11112222));

    repeat (3) @(negedge clk_i);
    chk("rst_en", {31'd0, mem_en_o}, 0);
    chk("rst_ack", {30'd0, if_ack_o, dm_ack_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", if_data_o | dm_rdata_o, 0);
    chk("rst_stall", {31'd0, stall_o}, 0);
    rst_i = 1'b1;

    foreach (tbl[i]) begin
      if_req_i = tbl[i].if_req;  if_addr_i = tbl[i].if_addr;
      dm_req_i = tbl[i].dm_req;  dm_we_i = tbl[i].dm_we;
      dm_addr_i = tbl[i].dm_addr; dm_wdata_i = tbl[i].dm_wdata;
      mem_ready_i = tbl[i].ready; mem_rdata_i = tbl[i].rdata;
      #1;
      chk($sformatf("v%0d_if_ack", i), {31'd0, if_ack_o}, {31'd0, tbl[i].e_if_ack});
      chk($sformatf("v%0d_dm_ack", i), {31'd0, dm_ack_o}, {31'd0, tbl[i].e_dm_ack});
      chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en_o}, {31'd0, tbl[i].e_en});
      chk($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, tbl[i].e_stall});
      chk($sformatf("v%0d_if_data", i), if_data_o, tbl[i].e_if_data);
      chk($sformatf("v%0d_dm_rdata", i), dm_rdata_o, tbl[i].e_dm_data);
      if (tbl[i].e_en) begin
        chk($sformatf("v%0d_mem_addr", i), mem_addr_o, tbl[i].e_addr);
        chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we_o}, {31'd0, tbl[i].e_we});
        if (tbl[i].e_we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata_o, tbl[i].e_wdata);
      end
      @(negedge clk_i);
    end

    // IF request dropped while granted still completes with an ack.
    idle_inputs();
    if_req_i = 1'b1; if_addr_i = 32'h44;
    #1 chk("drop_stall", {31'd0, stall_o}, 1);
    @(negedge clk_i);
    #1 chk("drop_en", {31'd0, mem_en_o}, 1);
    chk("drop_addr", mem_addr_o, 32'h44);
    if_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    #1 chk("drop_ack", {31'd0, if_ack_o}, 1);
    chk("drop_data", if_data_o, 32'h0BADF00D);
    @(negedge clk_i);
    #1 chk("drop_ack_gone", {31'd0, if_ack_o}, 0);
    @(negedge clk_i);

    // Starvation with STARVE_MAX=2: expect DM, DM, IF, DM.
    exp_order = '{1, 1, 0, 1};
    if_req_i = 1'b1; if_addr_i = 32'h100;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
    for (int cyc = 0; cyc < 60 && order.size() < 4; cyc++) begin
      #1;
      if (mem_en_o) begin mem_ready_i = 1'b1; mem_rdata_i = 32'h1234_0000 + cyc; end
      if (if_ack_o) begin order.push_back(0); if_req_i = 1'b0; end
      if (dm_ack_o) begin
        order.push_back(1);
        dm_addr_i = dm_addr_i + 32'd4;
        if (order.size() == 4) dm_req_i = 1'b0;
      end
      @(negedge clk_i);
      mem_ready_i = 1'b0;
    end
    chk("starve_count", order.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("starve_grant%0d", k), (k < order.size()) ? order[k] : -1, exp_order[k]);
    end
    idle_inputs();
    @(negedge clk_i);

    // Reset in the middle of a DM grant: everything clears, no ack follows.
    dm_req_i = 1'b1; dm_addr_i = 32'h300;
    @(negedge clk_i);
    #1 chk("rmid_en", {31'd0, mem_en_o}, 1);
    rst_i = 1'b0; dm_req_i = 1'b0;
    #1;
    chk("rmid_en0", {31'd0, mem_en_o}, 0);
    chk("rmid_addr0", mem_addr_o, 0);
    chk("rmid_data0", if_data_o | dm_rdata_o, 0);
    chk("rmid_misc0", {29'd0, if_ack_o, dm_ack_o, stall_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b1; mem_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("rmid_noack%0d", k), {30'd0, dm_ack_o, mem_en_o}, 0);
      @(negedge clk_i);
    end
    idle_inputs();

    // Randomized traffic against a transaction-level model.
    mode = 0; starve = 0; if_busy = 0; dm_busy = 0;
    m_if_data = '0; m_dm_data = '0;
    t_if = 0; t_we = 0; t_addr = '0; t_wdata = '0; wait_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (mode == 2 && t_if) begin
        if_busy = ($urandom % 2) == 1; if_req_i = if_busy; if_addr_i = {26'd0, 4'($urandom), 2'b00};
      end else if (!if_busy) begin
        if (($urandom % 3) == 0) begin if_busy = 1; if_req_i = 1'b1; if_addr_i = {26'd0, 4'($urandom), 2'b00}; end
      end else if (mode == 1 && t_if && if_req_i && ($urandom % 8) == 0) begin
        if_req_i = 1'b0;
      end
      if (mode == 2 && !t_if) begin
        dm_busy = ($urandom % 2) == 1; dm_req_i = dm_busy;
        dm_addr_i = {26'd0, 4'($urandom), 2'b00}; dm_we_i = $urandom % 2; dm_wdata_i = $urandom;
      end else if (!dm_busy) begin
        if (($urandom % 3) == 0) begin
          dm_busy = 1; dm_req_i = 1'b1;
          dm_addr_i = {26'd0, 4'($urandom), 2'b00}; dm_we_i = $urandom % 2; dm_wdata_i = $urandom;
        end
      end
      if (mode == 1) begin
        if (wait_left == 0) begin
          mem_ready_i = 1'b1; mem_rdata_i = t_we ? $urandom : mem_rd(t_addr);
        end else begin
          mem_ready_i = 1'b0; mem_rdata_i = $urandom; wait_left--;
        end
      end else begin
        mem_ready_i = ($urandom % 4) == 0; mem_rdata_i = $urandom;
      end
      #1;
      e_ia = (mode == 2) && t_if;
      e_da = (mode == 2) && !t_if;
      chk("rnd_mem_en", {31'd0, mem_en_o}, {31'd0, mode == 1});
      if (mode == 1) begin
        chk("rnd_mem_addr", mem_addr_o, t_addr);
        chk("rnd_mem_we", {31'd0, mem_we_o}, {31'd0, t_we});
        if (t_we) chk("rnd_mem_wdata", mem_wdata_o, t_wdata);
      end
      chk("rnd_if_ack", {31'd0, if_ack_o}, {31'd0, e_ia});
      chk("rnd_dm_ack", {31'd0, dm_ack_o}, {31'd0, e_da});
      chk("rnd_if_data", if_data_o, m_if_data);
      chk("rnd_dm_rdata", dm_rdata_o, m_dm_data);
      chk("rnd_stall", {31'd0, stall_o}, {31'd0, (if_req_i & ~e_ia) | (dm_req_i & ~e_da)});
      case (mode)
        0: if (if_req_i || dm_req_i) begin
             pick_if = !dm_req_i || (if_req_i && starve == SMAX);
             if (pick_if) starve = 0;
             else if (if_req_i && starve < SMAX) starve++;
             t_if = pick_if;
             t_addr = pick_if ? if_addr_i : dm_addr_i;
             t_we = !pick_if && dm_we_i;
             t_wdata = dm_wdata_i;
             wait_left = $urandom % 4;
             mode = 1;
           end
        1: if (mem_ready_i) begin
             if (t_we) mem[t_addr] = t_wdata;
             else if (t_if) m_if_data = mem_rdata_i;
             else m_dm_data = mem_rdata_i;
             mode = 2;
           end
        default: mode = 0;
      endcase
      @(negedge clk_i);
    end

    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
